ex_wb_buffer: RTL
=================

# ex_wb_buffer

Execute-to-writeback stage sitting directly downstream of the 8-bit ALU. Captures each ALU result (OUT, OVERFLOW, ZF) with its destination register and opcode, and holds the architectural flags register. Queues register writes in a small in-order FIFO so a stalled register-file write port does not stall the ALU. Supports a flush for discarding queued writes.

## Interface
Parameters:
- DEPTH, 2, number of FIFO entries (power of two, ≥2)
- DW, 8, data width (matches ALU)
- RA_W, 4, register address width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  execute stage presents a result this cycle
- IN_READY  out  1  block can accept; transfer when IN_VALID & IN_READY
- IN_OP  in  3  ALU opcode of the result
- IN_RES  in  DW  ALU OUT
- IN_OVF  in  2  ALU OVERFLOW
- IN_ZF  in  1  ALU ZF
- IN_WE  in  1  result must be written to a register
- IN_DST  in  RA_W  destination register
- WB_VALID  out  1  head entry ready for the register file
- WB_READY  in  1  register file accepts; pop when WB_VALID & WB_READY
- WB_DST  out  RA_W  head entry destination
- WB_DATA  out  DW  head entry data
- FLAG_OVF  out  2  architectural overflow flags
- FLAG_ZF  out  1  architectural zero flag
- FLUSH  in  1  synchronous discard of all queued writes
- COUNT  out  $clog2(DEPTH+1)  occupied FIFO entries

## Operation
- Accept = IN_VALID & IN_READY. On accept:
  - IN_WE=1: push {IN_DST, IN_RES} at tail.
  - IN_WE=0: nothing enqueued.
  - IN_OP=3'b100 (ADD): FLAG_OVF←IN_OVF, FLAG_ZF←IN_ZF.
  - Any other opcode: flags hold.
  - Flags update regardless of IN_WE.
- IN_READY = !RESET & !FLUSH & (COUNT < DEPTH).
  - No combinational path from WB_READY.
  - When full, a same-cycle pop does not open a slot.
- WB_VALID = (COUNT != 0) & !FLUSH. WB_DST/WB_DATA show the head entry.
  - Head is stable while WB_VALID & !WB_READY.
  - Output values are don't-care when WB_VALID=0, but must not be X after reset.
- Pop and push in the same cycle: COUNT unchanged, pointers both advance.
- FLUSH:
  - Highest priority. Next cycle COUNT=0 and pointers are reset.
  - No accept and no pop occur in the FLUSH cycle.
  - Flags are unaffected.
- Pointers wrap modulo DEPTH. COUNT never exceeds DEPTH or underflows.
- Ordering is strict FIFO. Every accepted IN_WE=1 entry not flushed appears exactly once on WB.

## Timing
- Reset values (asynchronous on RESET rise):
  - COUNT=0, WB_VALID=0, WB_DST=0, WB_DATA=0 (storage cleared).
  - FLAG_OVF=2'b00, FLAG_ZF=0.
  - IN_READY=0 while RESET is high; IN_READY=1 on the first cycle after deassertion.
- Result latency: accept at edge N makes the entry visible on WB from cycle N+1 when the FIFO was empty. There is no same-cycle bypass.
- Flag latency: the new flags are visible the cycle after an ADD accept.
- Throughput: one accept and one pop per cycle sustained while 0 < COUNT < DEPTH.
- RESET mid-operation discards all entries and flags immediately. Any in-flight handshake that cycle is void.
- FLUSH→WB_VALID is the only combinational input→output path besides the RESET/FLUSH→IN_READY gating.

## Structure
- Shared package cpu_pkg holds:
  - alu_op_t enum: AND=000, XOR=001, SHL=010, SHR=011, ADD=100.
  - flags_t packed struct {ovf[1:0], zf}.
  - wb_entry_t packed struct {dst, data}.
- The ALU and this block both import cpu_pkg.
- One sub-module, wb_fifo: a generic DEPTH×wb_entry_t synchronous FIFO with push, pop, flush, count, full, empty and asynchronous reset.
- ex_wb_buffer instantiates wb_fifo and adds the flag register and handshake gating.

## Test plan
- Reset, then ADD accept with IN_RES=0x00, IN_OVF=2'b01, IN_ZF=1, IN_WE=1, IN_DST=3 and WB_READY=1 -> next cycle WB_VALID=1, WB_DST=3, WB_DATA=0x00, FLAG_ZF=1, FLAG_OVF=01; the following cycle COUNT=0.
- ADD sets ZF=1, then XOR accept with IN_ZF=0 -> FLAG_ZF stays 1 and the XOR result is queued normally.
- WB_READY=0, then three accepts (0x11, 0x22, 0x33) -> IN_READY drops after two (COUNT=2). After WB_READY=1, pops occur in order 0x11 then 0x22, and 0x33 is accepted only once a slot frees.
- Sustained one accept and one pop per cycle for 10 cycles with COUNT=1 -> COUNT stays 1, data is in order, and pointers wrap with no loss.
- COUNT=2, then FLUSH for one cycle with IN_VALID=1 -> WB_VALID=0 and IN_READY=0 that cycle, COUNT=0 next cycle, no write is observed, and flags are unchanged.
- RESET asserted mid-stream with COUNT=2 and FLAG_ZF=1 -> all outputs return to reset values in the same cycle, asynchronously to CLK.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcodes, architectural flags and writeback queue entries.
// Imported by the ALU and by the execute-to-writeback buffer.
package cpu_pkg;

  localparam int CPU_DW   = 8;
  localparam int CPU_RA_W = 4;

  typedef enum logic [2:0] {
    AND = 3'b000,
    XOR = 3'b001,
    SHL = 3'b010,
    SHR = 3'b011,
    ADD = 3'b100
  } alu_op_t;

  typedef struct packed {
    logic [1:0] ovf;
    logic       zf;
  } flags_t;

  typedef struct packed {
    logic [CPU_RA_W-1:0] dst;
    logic [CPU_DW-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic in-order FIFO with flush and asynchronous reset.
// The head entry is read combinationally so it is visible the cycle after a push.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  entry_t                       din,
  output entry_t                       dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  // Storage is cleared on reset so the head output is never X.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ex_wb_buffer.sv
// Execute-to-writeback buffer: queues ALU register writes and holds the
// architectural flags, decoupling the ALU from a stalled register-file port.
module ex_wb_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int RA_W  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_op,
  input  logic [DW-1:0]                in_res,
  input  logic [1:0]                   in_ovf,
  input  logic                         in_zf,
  input  logic                         in_we,
  input  logic [RA_W-1:0]              in_dst,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [RA_W-1:0]              wb_dst,
  output logic [DW-1:0]                wb_data,
  output logic [1:0]                   flag_ovf,
  output logic                         flag_zf,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  typedef struct packed {
    logic [RA_W-1:0] dst;
    logic [DW-1:0]   data;
  } entry_t;

  entry_t  push_entry;
  entry_t  head_entry;
  flags_t  flags_reg;
  logic    full;
  logic    empty;
  logic    accept;
  logic    pop;

  // Readiness depends only on occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready   = ~reset & ~flush & ~full;
  assign accept     = in_valid & in_ready;
  assign wb_valid   = ~empty & ~flush;
  assign pop        = wb_valid & wb_ready;
  assign push_entry = '{dst: in_dst, data: in_res};
  assign wb_dst     = head_entry.dst;
  assign wb_data    = head_entry.data;
  assign flag_ovf   = flags_reg.ovf;
  assign flag_zf    = flags_reg.zf;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (accept & in_we),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Only ADD updates the flags, whether or not its result is written back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= '0;
    end else if (accept && (alu_op_t'(in_op) == ADD)) begin
      flags_reg <= '{ovf: in_ovf, zf: in_zf};
    end
  end

endmodule
